// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: one full-adder cell stepped LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the `sub` port (a - b via inverted B and carry-in of 1).
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic               accept_s;
   logic               sub_s;
   logic               last_bit_s;
   logic [WIDTH-1:0]   a_sr_r;
   logic [WIDTH-1:0]   b_sr_r;
   logic [WIDTH-2:0]   r_sr_r;
   logic [WIDTH-1:0]   r_sr_nxt_s;
   logic [WIDTH-1:0]   sum_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               carry_r;
   logic               cout_r;
   logic               busy_r;
   logic               done_r;
   logic               ha0_sum_s;
   logic               ha0_carry_s;
   logic               bit_sum_s;
   logic               bit_carry_s;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_s = sub;
`else
   assign sub_s = 1'b0;
`endif

   // Full adder built from two half adders plus the carry OR.
   assign ha0_sum_s   = a_sr_r[0] ^ b_sr_r[0];
   assign ha0_carry_s = a_sr_r[0] & b_sr_r[0];
   assign bit_sum_s   = ha0_sum_s ^ carry_r;
   assign bit_carry_s = ha0_carry_s | (ha0_sum_s & carry_r);

   assign last_bit_s  = (cnt_r == {CNT_W{1'b0}});
   assign r_sr_nxt_s  = {bit_sum_s, r_sr_r};

   // Next-state logic; DONE accepts a new request directly for back-to-back issue.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               accept_s    = 1'b1;
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (last_bit_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE: begin
            if (start) begin
               accept_s    = 1'b1;
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand shifters, carry, bit counter and the result/handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr_r  <= {WIDTH{1'b0}};
         b_sr_r  <= {WIDTH{1'b0}};
         r_sr_r  <= {(WIDTH-1){1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         cout_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s == RUN);
         done_r <= (state_nxt_s == DONE);
         if (accept_s) begin
            a_sr_r  <= a;
            b_sr_r  <= sub_s ? ~b : b;
            carry_r <= sub_s;
            r_sr_r  <= {(WIDTH-1){1'b0}};
            cnt_r   <= CNT_W'(WIDTH - 1);
         end else if (state_r == RUN) begin
            a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
            b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
            r_sr_r  <= r_sr_nxt_s[WIDTH-1:1];
            carry_r <= bit_carry_s;
            if (last_bit_s) begin
               // Only the final bit publishes; partial results stay internal.
               sum_r  <= r_sr_nxt_s;
               cout_r <= bit_carry_s;
            end else begin
               cnt_r <= cnt_r - CNT_W'(1);
            end
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign sum  = sum_r;
   assign cout = cout_r;

endmodule
